// File: rtl/game_pkg.sv
// Shared types and defaults for the level-flow controller: the game state
// encoding and the diamond-count clamp used on the eat-tracker inputs.
package game_pkg;

  typedef enum logic [2:0] {
    TITLE   = 3'd0,
    LVL_RST = 3'd1,
    PLAY    = 3'd2,
    WIN     = 3'd3,
    LOSE    = 3'd4
  } state_t;

  localparam int DEF_FRAMES_PER_SEC = 60;
  localparam int DEF_MAX_SECONDS    = 999;

  function automatic logic [3:0] clamp_eat(input logic [3:0] n, input logic [3:0] lim);
    return (n > lim) ? lim : n;
  endfunction

endpackage

// File: rtl/game_flow_ctrl_frame_sec_timer.sv
// Level timer: counts frame ticks into whole seconds, saturating the
// seconds count while the frame counter keeps wrapping.
module frame_sec_timer
  import game_pkg::*;
#(
  parameter int FRAMES_PER_SEC = DEF_FRAMES_PER_SEC,
  parameter int MAX_SECONDS    = DEF_MAX_SECONDS
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       frame_tick,
  output logic [9:0] timer_sec
);

  localparam int FW = $clog2(FRAMES_PER_SEC + 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_SEC - 1);
  localparam logic [9:0]    SEC_MAX    = 10'(MAX_SECONDS);

  logic [FW-1:0] frame_q, frame_d;
  logic [9:0]    sec_q, sec_d;

  always_comb begin
    frame_d = frame_q;
    sec_d   = sec_q;
    if (clear) begin
      frame_d = '0;
      sec_d   = '0;
    end else if (enable && frame_tick) begin
      if (frame_q == FRAME_LAST) begin
        frame_d = '0;
        if (sec_q < SEC_MAX) sec_d = sec_q + 10'd1;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_q <= '0;
      sec_q   <= '0;
    end else begin
      frame_q <= frame_d;
      sec_q   <= sec_d;
    end
  end

  assign timer_sec = sec_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// Level-flow controller: TITLE -> LVL_RST -> PLAY -> WIN/LOSE -> restart,
// with door-hold win detection, level timer and score latching.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int FRAMES_PER_SEC   = DEF_FRAMES_PER_SEC,
  parameter int MAX_SECONDS      = DEF_MAX_SECONDS,
  parameter int DIAMONDS_PER_CLR = 3,
  parameter int DOOR_HOLD_FRAMES = 30,
  parameter int PTS_PER_DIAMOND  = 10
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       keyboardpress,
  input  logic       restart_key,
  input  logic [3:0] num_eat_blue,
  input  logic [3:0] num_eat_red,
  input  logic       girl_at_door,
  input  logic       boy_at_door,
  input  logic       girl_dead,
  input  logic       boy_dead,
  output logic [2:0] game_state,
  output logic       level_reset,
  output logic [9:0] timer_sec,
  output logic [9:0] score,
  output logic       all_diamonds,
  output logic       show_title,
  output logic       show_win,
  output logic       show_lose
);

  localparam int DW = $clog2(DOOR_HOLD_FRAMES + 1);
  localparam logic [DW-1:0] DOOR_DONE  = DW'(DOOR_HOLD_FRAMES);
  localparam logic [3:0]    DPC        = 4'(DIAMONDS_PER_CLR);
  localparam logic [9:0]    PTS        = 10'(PTS_PER_DIAMOND);
  localparam logic [9:0]    BONUS_BASE = 10'd100;

  state_t        state_q, state_d;
  logic [DW-1:0] door_q, door_d;
  logic [9:0]    score_q, score_d;
  logic          all_q, all_d;

  logic [3:0]    blue_c, red_c;
  logic [9:0]    diamond_pts, time_bonus;
  logic [DW-1:0] door_inc;
  logic          both_at_door, any_dead, hold_done;
  logic          timer_clear, timer_enable;

  assign blue_c       = clamp_eat(num_eat_blue, DPC);
  assign red_c        = clamp_eat(num_eat_red, DPC);
  assign diamond_pts  = PTS * (10'(blue_c) + 10'(red_c));
  assign time_bonus   = (timer_sec < BONUS_BASE) ? (BONUS_BASE - timer_sec) : 10'd0;
  assign both_at_door = girl_at_door & boy_at_door;
  assign any_dead     = girl_dead | boy_dead;
  assign door_inc     = door_q + 1'b1;
  assign hold_done    = frame_tick && both_at_door && (door_inc == DOOR_DONE);

  always_comb begin
    state_d = state_q;
    door_d  = door_q;
    score_d = score_q;
    all_d   = (blue_c == DPC) && (red_c == DPC);
    case (state_q)
      TITLE: begin
        if (keyboardpress) state_d = LVL_RST;
      end
      LVL_RST: begin
        state_d = PLAY;
        door_d  = '0;
        score_d = '0;
      end
      PLAY: begin
        score_d = diamond_pts;
        if (frame_tick) door_d = both_at_door ? door_inc : '0;
        // Death outranks a door-hold completing in the same cycle.
        if (any_dead) begin
          state_d = LOSE;
        end else if (hold_done) begin
          state_d = WIN;
          score_d = diamond_pts + time_bonus;
        end else if (restart_key) begin
          state_d = LVL_RST;
          door_d  = '0;
          score_d = '0;
        end
      end
      WIN, LOSE: begin
        if (restart_key) begin
          state_d = LVL_RST;
          door_d  = '0;
          score_d = '0;
        end
      end
      default: state_d = TITLE;
    endcase
  end

  // Clearing on entry keeps timer_sec at 0 throughout LVL_RST.
  assign timer_clear  = (state_d == LVL_RST);
  assign timer_enable = (state_q == PLAY);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= TITLE;
      door_q  <= '0;
      score_q <= '0;
      all_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      door_q  <= door_d;
      score_q <= score_d;
      all_q   <= all_d;
    end
  end

  frame_sec_timer #(
    .FRAMES_PER_SEC(FRAMES_PER_SEC),
    .MAX_SECONDS   (MAX_SECONDS)
  ) u_timer (
    .Clk       (Clk),
    .Reset     (Reset),
    .clear     (timer_clear),
    .enable    (timer_enable),
    .frame_tick(frame_tick),
    .timer_sec (timer_sec)
  );

  assign game_state   = state_q;
  assign level_reset  = (state_q == LVL_RST);
  assign score        = score_q;
  assign all_diamonds = all_q;
  assign show_title   = (state_q == TITLE);
  assign show_win     = (state_q == WIN);
  assign show_lose    = (state_q == LOSE);

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: two instances (60 and 1 frames per second) share
// stimulus and are checked every cycle against a rule-level reference model.
module tb_game_flow_ctrl;

  localparam int S_TITLE = 0, S_LVL = 1, S_PLAY = 2, S_WIN = 3, S_LOSE = 4;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_tick = 1'b0, keyboardpress = 1'b0, restart_key = 1'b0;
  logic [3:0] num_eat_blue = 4'd0, num_eat_red = 4'd0;
  logic       girl_at_door = 1'b0, boy_at_door = 1'b0, girl_dead = 1'b0, boy_dead = 1'b0;

  logic [2:0] gs [2];
  logic       lr [2], ad [2], st [2], sw [2], sl [2];
  logic [9:0] tm [2], sc [2];

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int m_state = S_TITLE;
  int m_ticks = 0;
  int m_run   = 0;
  int m_score [2] = '{0, 0};
  int m_all   = 0;
  int fps     [2] = '{60, 1};

  always #5 Clk = ~Clk;

  game_flow_ctrl #(.FRAMES_PER_SEC(60)) dut0 (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .keyboardpress(keyboardpress),
    .restart_key(restart_key), .num_eat_blue(num_eat_blue), .num_eat_red(num_eat_red),
    .girl_at_door(girl_at_door), .boy_at_door(boy_at_door), .girl_dead(girl_dead),
    .boy_dead(boy_dead), .game_state(gs[0]), .level_reset(lr[0]), .timer_sec(tm[0]),
    .score(sc[0]), .all_diamonds(ad[0]), .show_title(st[0]), .show_win(sw[0]),
    .show_lose(sl[0])
  );

  game_flow_ctrl #(.FRAMES_PER_SEC(1)) dut1 (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .keyboardpress(keyboardpress),
    .restart_key(restart_key), .num_eat_blue(num_eat_blue), .num_eat_red(num_eat_red),
    .girl_at_door(girl_at_door), .boy_at_door(boy_at_door), .girl_dead(girl_dead),
    .boy_dead(boy_dead), .game_state(gs[1]), .level_reset(lr[1]), .timer_sec(tm[1]),
    .score(sc[1]), .all_diamonds(ad[1]), .show_title(st[1]), .show_win(sw[1]),
    .show_lose(sl[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp3(input int n);
    return (n > 3) ? 3 : n;
  endfunction

  function automatic int exp_timer(input int k);
    int s;
    s = m_ticks / fps[k];
    return (s > 999) ? 999 : s;
  endfunction

  function automatic int diamond_pts();
    return 10 * (clamp3(int'(num_eat_blue)) + clamp3(int'(num_eat_red)));
  endfunction

  // Apply the game rules to the inputs presented for the coming edge.
  task automatic model_step();
    int pts, run_n, bonus;
    pts = diamond_pts();
    if (Reset) begin
      m_state = S_TITLE; m_ticks = 0; m_run = 0;
      m_score[0] = 0; m_score[1] = 0; m_all = 0;
      return;
    end
    m_all = (clamp3(int'(num_eat_blue)) == 3 && clamp3(int'(num_eat_red)) == 3) ? 1 : 0;
    case (m_state)
      S_TITLE: if (keyboardpress) m_state = S_LVL;
      S_LVL: begin
        m_state = S_PLAY; m_ticks = 0; m_run = 0;
        m_score[0] = 0; m_score[1] = 0;
      end
      S_PLAY: begin
        run_n = m_run;
        if (frame_tick) run_n = (girl_at_door && boy_at_door) ? m_run + 1 : 0;
        if (girl_dead || boy_dead) begin
          m_state = S_LOSE; m_score[0] = pts; m_score[1] = pts;
        end else if (run_n >= 30) begin
          m_state = S_WIN;
          for (int k = 0; k < 2; k++) begin
            bonus = 100 - exp_timer(k);
            m_score[k] = pts + ((bonus > 0) ? bonus : 0);
          end
        end else if (restart_key) begin
          m_state = S_LVL; m_score[0] = 0; m_score[1] = 0;
        end else begin
          m_score[0] = pts; m_score[1] = pts;
        end
        m_run = run_n;
        if (m_state == S_LVL) begin
          m_ticks = 0; m_run = 0;
        end else if (frame_tick) begin
          m_ticks++;
        end
      end
      default: begin
        if (restart_key) begin
          m_state = S_LVL; m_ticks = 0; m_run = 0;
          m_score[0] = 0; m_score[1] = 0;
        end
      end
    endcase
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("state%0d", k), 32'(gs[k]), 32'(m_state));
      chk($sformatf("level_reset%0d", k), 32'(lr[k]), 32'(m_state == S_LVL));
      chk($sformatf("timer%0d", k), 32'(tm[k]), 32'(exp_timer(k)));
      chk($sformatf("score%0d", k), 32'(sc[k]), 32'(m_score[k]));
      chk($sformatf("all_diamonds%0d", k), 32'(ad[k]), 32'(m_all));
      chk($sformatf("show_title%0d", k), 32'(st[k]), 32'(m_state == S_TITLE));
      chk($sformatf("show_win%0d", k), 32'(sw[k]), 32'(m_state == S_WIN));
      chk($sformatf("show_lose%0d", k), 32'(sl[k]), 32'(m_state == S_LOSE));
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge Clk);
    #1;
    check_all();
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
    cycle();
  endtask

  task automatic pulse_restart();
    restart_key = 1'b1;
    cycle();
    restart_key = 1'b0;
  endtask

  initial begin
    int b, r, pts;

    // reset and idle title
    #1;
    cycle();
    cycle();
    Reset = 1'b0;
    chk("reset_state", 32'(gs[0]), S_TITLE);
    chk("reset_score", 32'(sc[0]), 0);
    cycle();
    cycle();
    chk("title_idle", 32'(gs[0]), S_TITLE);

    // leave title, run to 5 s, then reset mid-play
    keyboardpress = 1'b1;
    cycle();
    chk("lvl_rst_pulse", 32'(lr[0]), 1);
    cycle();
    chk("enter_play", 32'(gs[0]), S_PLAY);
    chk("pulse_done", 32'(lr[0]), 0);
    num_eat_blue = 4'd1;
    for (int i = 0; i < 300; i++) tick();
    chk("timer_5s", 32'(tm[0]), 5);
    Reset = 1'b1;
    cycle();
    Reset = 1'b0;
    chk("midplay_reset_state", 32'(gs[0]), S_TITLE);
    chk("midplay_reset_timer", 32'(tm[0]), 0);
    chk("midplay_reset_score", 32'(sc[0]), 0);
    chk("midplay_reset_lr", 32'(lr[0]), 0);

    // sticky key leaves title again; 120 ticks -> 2 s
    cycle();
    chk("relaunch_lr", 32'(lr[0]), 1);
    cycle();
    chk("relaunch_lr_low", 32'(lr[0]), 0);
    for (int i = 0; i < 120; i++) tick();
    chk("timer_2s", 32'(tm[0]), 2);
    chk("timer_fps1_120", 32'(tm[1]), 120);

    // clamp and score with random diamond counts
    num_eat_blue = 4'd7; num_eat_red = 4'd3;
    cycle();
    cycle();
    chk("clamp_all", 32'(ad[0]), 1);
    chk("clamp_score", 32'(sc[0]), 60);
    for (int i = 0; i < 12; i++) begin
      num_eat_blue = 4'($urandom_range(0, 15));
      num_eat_red  = 4'($urandom_range(0, 15));
      cycle();
      cycle();
    end

    // run to 40 s without a full door hold, then a broken and a full hold
    num_eat_blue = 4'd2; num_eat_red = 4'd3;
    for (int i = 0; i < 2280; i++) begin
      girl_at_door = 1'($urandom_range(0, 1));
      boy_at_door  = 1'b0;
      tick();
    end
    chk("timer_40s", 32'(tm[0]), 40);
    chk("timer_saturated", 32'(tm[1]), 999);
    girl_at_door = 1'b1; boy_at_door = 1'b1;
    for (int i = 0; i < 28; i++) tick();
    boy_at_door = 1'b0;
    tick();
    boy_at_door = 1'b1;
    for (int i = 0; i < 29; i++) tick();
    chk("hold_29_no_win", 32'(gs[0]), S_PLAY);
    tick();
    chk("win_state", 32'(gs[0]), S_WIN);
    chk("win_score", 32'(sc[0]), 110);
    chk("win_score_no_bonus", 32'(sc[1]), 50);
    girl_dead = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    girl_dead = 1'b0;
    chk("win_ignores_death", 32'(gs[0]), S_WIN);
    chk("win_timer_hold", 32'(tm[0]), 40);

    // restart, then death on the 30th hold tick
    pulse_restart();
    chk("restart_lr", 32'(lr[1]), 1);
    chk("restart_timer", 32'(tm[1]), 0);
    cycle();
    b = int'($urandom_range(0, 9)); r = int'($urandom_range(0, 9));
    num_eat_blue = 4'(b); num_eat_red = 4'(r);
    pts = 10 * (clamp3(b) + clamp3(r));
    for (int i = 0; i < 29; i++) tick();
    girl_dead = 1'b1;
    tick();
    girl_dead = 1'b0;
    chk("death_beats_win", 32'(gs[0]), S_LOSE);
    chk("lose_score", 32'(sc[0]), 32'(pts));

    // restart and death together in play
    pulse_restart();
    cycle();
    girl_at_door = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    restart_key = 1'b1; boy_dead = 1'b1;
    cycle();
    restart_key = 1'b0; boy_dead = 1'b0;
    chk("death_beats_restart", 32'(gs[0]), S_LOSE);

    // back to play, timer restarts from zero
    pulse_restart();
    cycle();
    chk("replay_state", 32'(gs[1]), S_PLAY);
    for (int i = 0; i < 5; i++) tick();
    chk("replay_timer", 32'(tm[1]), 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
